// File: rtl/pulse_pacer_if.sv
// Source-side signal bundle for pulse_pacer.
// The flush member exists only when PULSE_PACER_FLUSH_EN is defined.
interface pulse_pacer_if #(
  parameter int unsigned pCNT_W = 4
);
  logic              in_pls;
  logic              ovf_clr;
`ifdef PULSE_PACER_FLUSH_EN
  logic              flush;
`endif
  logic              out_pls;
  logic [pCNT_W-1:0] pending;
  logic              busy;
  logic              ovf;

`ifdef PULSE_PACER_FLUSH_EN
  modport master (output in_pls, ovf_clr, flush,
                  input  out_pls, pending, busy, ovf);
  modport slave  (input  in_pls, ovf_clr, flush,
                  output out_pls, pending, busy, ovf);
`else
  modport master (output in_pls, ovf_clr,
                  input  out_pls, pending, busy, ovf);
  modport slave  (input  in_pls, ovf_clr,
                  output out_pls, pending, busy, ovf);
`endif
endinterface

// File: rtl/pulse_pacer.sv
// Queues event pulses and re-emits them spaced at least pGAP cycles apart.
// Optional backlog flush input enabled by defining PULSE_PACER_FLUSH_EN.
module pulse_pacer #(
  parameter int unsigned pGAP   = 6,
  parameter int unsigned pCNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  pulse_pacer_if.slave  pp
);

  typedef enum logic {IDLE, GAP} state_t;

  localparam logic [7:0]        GAP_LOAD = 8'(pGAP - 1);
  localparam logic [pCNT_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic [pCNT_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              flush_w;
  logic              issue, accept, drop;

`ifdef PULSE_PACER_FLUSH_EN
  assign flush_w = pp.flush;
`else
  assign flush_w = 1'b0;
`endif

  // in_pls bypasses the backlog when idle, so an issue with pending == 0 is legal
  assign issue  = (state_q == IDLE) && ((pend_q != '0) || pp.in_pls) && !flush_w;
  assign accept = pp.in_pls && !flush_w && ((pend_q != PEND_MAX) || issue);
  assign drop   = pp.in_pls && !flush_w && !accept;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    out_d   = 1'b0;
    ovf_d   = ovf_q;

    // Leaving GAP on the count of 1 lands in IDLE with gap_cnt == 0, giving pGAP spacing
    if (state_q == GAP) begin
      gap_d = gap_q - 8'd1;
      if (gap_q == 8'd1) state_d = IDLE;
    end

    if (issue) begin
      out_d   = 1'b1;
      state_d = GAP;
      gap_d   = GAP_LOAD;
    end

    if (flush_w)
      pend_d = '0;
    else if (accept && !issue)
      pend_d = pend_q + 1'b1;
    else if (issue && !accept)
      pend_d = pend_q - 1'b1;

    if (drop)
      ovf_d = 1'b1;
    else if (pp.ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pp.out_pls = out_q;
  assign pp.pending = pend_q;
  assign pp.ovf     = ovf_q;
  assign pp.busy    = (pend_q != '0) || (state_q == GAP);

endmodule
